tri_err_fir: RTL and testbench

Parametrised error-collection register, successor to the single-purpose error reporter. It is placed beside each unit's local error sources and feeds the central fault-isolation logic. It holds errors stickily with a software clear, keeps a writable per-bit mask, captures the index of the first unmasked error, and raises a req/ack report to the collector. An optional saturating occurrence counter can be compiled in.

---
 rtl/tri_err_fir.sv | 162 ++++++++++++++++
 tb/tb_tri_err_fir.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_err_fir.sv
// tri_err_fir: sticky error register with mask, first-error capture and
// req/ack reporting. Define TRI_ERR_FIR_CNT_EN for the occurrence counter.
module tri_err_fir #(
    parameter int                 WIDTH            = 8,
    parameter logic [WIDTH-1:0]   MASK_RESET_VALUE = {WIDTH{1'b0}},
    parameter bit                 INLINE           = 1'b0,
    parameter int                 CNT_WIDTH        = 4,
    localparam int                IDXW             = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     err_in,
    input  logic [WIDTH-1:0]     hold_clr,
    input  logic                 mask_wr,
    input  logic [WIDTH-1:0]     mask_wdata,
    input  logic                 first_clr,
    input  logic                 cnt_clr,
    input  logic                 rpt_ack,
    output logic [WIDTH-1:0]     err_out,
    output logic [WIDTH-1:0]     hold_out,
    output logic [WIDTH-1:0]     mask_out,
    output logic                 first_valid,
    output logic [IDXW-1:0]      first_idx,
    output logic                 rpt_req,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic                 cnt_sat
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACKED = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_mask;
    logic             r_first_valid;
    logic [IDXW-1:0]  r_first_idx;
    state_t           r_state;
    logic             r_rpt_req;

    logic [WIDTH-1:0] w_u;
    logic             w_u_any;
    logic [WIDTH-1:0] w_held_unmasked;
    logic [IDXW-1:0]  w_low_idx;

    assign w_u             = err_in & ~r_mask;
    assign w_u_any         = |w_u;
    assign w_held_unmasked = r_hold & ~r_mask;

    // lowest set index of the unmasked error vector
    always_comb begin
        w_low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_u[i]) begin
                w_low_idx = IDXW'(i);
            end
        end
    end

    // sticky hold: a new error in the same cycle beats its clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else begin
            r_hold <= (r_hold & ~hold_clr) | err_in;
        end
    end

    // writable mask, effective for u from the next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= MASK_RESET_VALUE;
        end else if (mask_wr) begin
            r_mask <= mask_wdata;
        end
    end

    // first-error capture; a fresh error beats a same-cycle re-arm
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
        end else if (w_u_any && (!r_first_valid || first_clr)) begin
            r_first_valid <= 1'b1;
            r_first_idx   <= w_low_idx;
        end else if (first_clr) begin
            r_first_valid <= 1'b0;
        end
    end

    // report handshake: one request per episode of unmasked errors
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rpt_req <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_u_any) begin
                        r_state   <= ST_REQ;
                        r_rpt_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (rpt_ack) begin
                        r_state   <= ST_ACKED;
                        r_rpt_req <= 1'b0;
                    end
                end
                ST_ACKED: begin
                    if (w_held_unmasked == '0) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_rpt_req <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (INLINE) begin : g_inline
            assign err_out = w_held_unmasked;
        end else begin : g_live
            assign err_out = w_u;
        end
    endgenerate

`ifdef TRI_ERR_FIR_CNT_EN
    logic [CNT_WIDTH-1:0] r_cnt;

    // saturating count of cycles with any unmasked error; clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_u_any && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign cnt_out = r_cnt;
    assign cnt_sat = &r_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign cnt_out          = '0;
    assign cnt_sat          = 1'b0;
`endif

    assign hold_out    = r_hold;
    assign mask_out    = r_mask;
    assign first_valid = r_first_valid;
    assign first_idx   = r_first_idx;
    assign rpt_req     = r_rpt_req;

endmodule

// File: tb/tb_tri_err_fir.sv
// tb_tri_err_fir: scoreboard bench for tri_err_fir, live and held
// err_out variants side by side.
module tb_tri_err_fir;

`ifdef TRI_ERR_FIR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int SEL_EO0  = 0;
    localparam int SEL_HO0  = 1;
    localparam int SEL_FV0  = 2;
    localparam int SEL_FI0  = 3;
    localparam int SEL_RQ0  = 4;
    localparam int SEL_CNT0 = 5;
    localparam int SEL_SAT0 = 6;
    localparam int SEL_MK0  = 7;
    localparam int SEL_EO1  = 8;
    localparam int SEL_HO1  = 9;
    localparam int SEL_RQ1  = 10;
    localparam int SEL_MK1  = 11;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] err_in;
    logic [7:0] hold_clr;
    logic       mask_wr;
    logic [7:0] mask_wdata;
    logic       first_clr;
    logic       cnt_clr;
    logic       rpt_ack;

    logic [7:0] eo0, ho0, mo0;
    logic       fv0, rq0, sat0;
    logic [2:0] fi0;
    logic [3:0] cnt0;
    logic [7:0] eo1, ho1, mo1;
    logic       fv1, rq1, sat1;
    logic [2:0] fi1;
    logic [3:0] cnt1;

    int   cyc;
    int   checks;
    int   errors;
    exp_t sbq[$];

    tri_err_fir #(
        .WIDTH(8), .MASK_RESET_VALUE(8'h0F), .INLINE(1'b0), .CNT_WIDTH(4)
    ) u_live (
        .clk(clk), .rst(rst), .err_in(err_in), .hold_clr(hold_clr),
        .mask_wr(mask_wr), .mask_wdata(mask_wdata), .first_clr(first_clr),
        .cnt_clr(cnt_clr), .rpt_ack(rpt_ack), .err_out(eo0),
        .hold_out(ho0), .mask_out(mo0), .first_valid(fv0),
        .first_idx(fi0), .rpt_req(rq0), .cnt_out(cnt0), .cnt_sat(sat0)
    );

    tri_err_fir #(
        .WIDTH(8), .MASK_RESET_VALUE(8'h00), .INLINE(1'b1), .CNT_WIDTH(4)
    ) u_held (
        .clk(clk), .rst(rst), .err_in(err_in), .hold_clr(hold_clr),
        .mask_wr(mask_wr), .mask_wdata(mask_wdata), .first_clr(first_clr),
        .cnt_clr(cnt_clr), .rpt_ack(rpt_ack), .err_out(eo1),
        .hold_out(ho1), .mask_out(mo1), .first_valid(fv1),
        .first_idx(fi1), .rpt_req(rq1), .cnt_out(cnt1), .cnt_sat(sat1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] act(int sel);
        case (sel)
            SEL_EO0:  return {24'd0, eo0};
            SEL_HO0:  return {24'd0, ho0};
            SEL_FV0:  return {31'd0, fv0};
            SEL_FI0:  return {29'd0, fi0};
            SEL_RQ0:  return {31'd0, rq0};
            SEL_CNT0: return {28'd0, cnt0};
            SEL_SAT0: return {31'd0, sat0};
            SEL_MK0:  return {24'd0, mo0};
            SEL_EO1:  return {24'd0, eo1};
            SEL_HO1:  return {24'd0, ho1};
            SEL_RQ1:  return {31'd0, rq1};
            SEL_MK1:  return {24'd0, mo1};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        int i;
        logic [31:0] a;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].cyc == cyc) begin
                a = act(sbq[i].sel);
                checks++;
                if (a !== sbq[i].exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h",
                             sbq[i].name, cyc, a, sbq[i].exp);
                end
                sbq.delete(i);
            end else if (sbq[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s stale cyc=%0d got=none exp=%h",
                         sbq[i].name, sbq[i].cyc, sbq[i].exp);
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expect_at(int dly, int sel, logic [31:0] v, string nm);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        err_in     = 8'h00;
        hold_clr   = 8'h00;
        mask_wr    = 1'b0;
        mask_wdata = 8'h00;
        first_clr  = 1'b0;
        cnt_clr    = 1'b0;
        rpt_ack    = 1'b0;
    endtask

    function automatic logic [31:0] cv(int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_in();

        tick();
        err_in = 8'h3C;
        expect_at(0, SEL_EO0, 32'h30, "rst_eo_live");
        expect_at(0, SEL_EO1, 32'h00, "rst_eo_held");
        tick();
        rst = 1'b0;
        idle_in();
        expect_at(0, SEL_HO0, 32'h00, "rst_hold");
        expect_at(0, SEL_MK0, 32'h0F, "rst_mask");
        expect_at(0, SEL_FV0, 32'h0, "rst_fv");
        expect_at(0, SEL_FI0, 32'h0, "rst_fi");
        expect_at(0, SEL_RQ0, 32'h0, "rst_req");
        expect_at(0, SEL_CNT0, 32'h0, "rst_cnt");
        expect_at(0, SEL_SAT0, 32'h0, "rst_sat");

        tick();
        err_in = 8'hFF;
        expect_at(0, SEL_EO0, 32'hF0, "ff_eo");
        expect_at(1, SEL_HO0, 32'hFF, "ff_hold");
        expect_at(1, SEL_FV0, 32'h1, "ff_fv");
        expect_at(1, SEL_FI0, 32'h4, "ff_fi");
        expect_at(1, SEL_RQ0, 32'h1, "ff_req");
        expect_at(1, SEL_CNT0, cv(1), "ff_cnt");
        expect_at(1, SEL_EO1, 32'hFF, "ff_eo_held");
        expect_at(1, SEL_RQ1, 32'h1, "ff_req_held");
        tick();
        idle_in();
        tick();
        err_in   = 8'h04;
        hold_clr = 8'h04;
        expect_at(1, SEL_HO0, 32'hFF, "set_beats_clr");
        expect_at(1, SEL_CNT0, cv(1), "masked_no_cnt");
        tick();
        idle_in();
        hold_clr = 8'h04;
        expect_at(1, SEL_HO0, 32'hFB, "clr_bit2");
        tick();
        idle_in();
        rpt_ack = 1'b1;
        expect_at(1, SEL_RQ0, 32'h0, "ack_drop");
        tick();
        idle_in();
        err_in = 8'h20;
        expect_at(0, SEL_EO0, 32'h20, "eo_bit5");
        expect_at(1, SEL_RQ0, 32'h0, "no_rereq");
        expect_at(1, SEL_CNT0, cv(2), "cnt2");
        tick();
        idle_in();
        hold_clr = 8'hF0;
        expect_at(1, SEL_HO0, 32'h0B, "clr_unmasked");
        tick();
        idle_in();
        expect_at(1, SEL_RQ0, 32'h0, "idle_no_req");
        tick();
        err_in = 8'h10;
        expect_at(1, SEL_RQ0, 32'h1, "rereq");
        tick();
        idle_in();
        first_clr = 1'b1;
        expect_at(1, SEL_FV0, 32'h0, "first_rearm");
        expect_at(1, SEL_FI0, 32'h4, "first_idx_kept");
        tick();
        idle_in();
        mask_wr    = 1'b1;
        mask_wdata = 8'h00;
        err_in     = 8'h01;
        expect_at(0, SEL_EO0, 32'h00, "mask_not_yet");
        expect_at(1, SEL_MK0, 32'h00, "mask_written");
        expect_at(1, SEL_FV0, 32'h0, "masked_no_cap");
        tick();
        idle_in();
        err_in = 8'h08;
        expect_at(0, SEL_EO0, 32'h08, "mask_live");
        expect_at(1, SEL_FV0, 32'h1, "cap3_fv");
        expect_at(1, SEL_FI0, 32'h3, "cap3_idx");
        tick();
        first_clr = 1'b1;
        err_in    = 8'h40;
        expect_at(0, SEL_EO0, 32'h40, "eo_bit6");
        expect_at(1, SEL_FV0, 32'h1, "cap_wins_fv");
        expect_at(1, SEL_FI0, 32'h6, "cap_wins_idx");
        expect_at(1, SEL_CNT0, cv(5), "cnt5");
        tick();
        idle_in();
        first_clr = 1'b1;
        expect_at(1, SEL_FV0, 32'h0, "first_clr2");

        for (int k = 0; k < 20; k++) begin
            tick();
            idle_in();
            err_in = 8'h01;
            if (k == 8) begin
                expect_at(1, SEL_CNT0, cv(14), "cnt14");
                expect_at(1, SEL_SAT0, 32'h0, "sat_not_yet");
            end
            if (k == 19) begin
                expect_at(1, SEL_CNT0, cv(15), "cnt_sat_val");
                expect_at(1, SEL_SAT0, cv(1), "cnt_sat_flag");
            end
        end
        tick();
        err_in  = 8'h01;
        cnt_clr = 1'b1;
        expect_at(1, SEL_CNT0, 32'h0, "cnt_clr_wins");
        expect_at(1, SEL_SAT0, 32'h0, "sat_cleared");
        tick();
        cnt_clr = 1'b0;
        expect_at(1, SEL_CNT0, cv(1), "cnt_restart");

        tick();
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        err_in = 8'h01;
        expect_at(0, SEL_MK1, 32'h00, "held_mask_rst");
        expect_at(0, SEL_EO1, 32'h00, "held_eo_rst");
        expect_at(1, SEL_EO1, 32'h01, "held_eo");
        expect_at(1, SEL_HO1, 32'h01, "held_hold");
        expect_at(1, SEL_RQ1, 32'h1, "held_req");
        tick();
        idle_in();
        mask_wr    = 1'b1;
        mask_wdata = 8'h01;
        expect_at(0, SEL_EO1, 32'h01, "held_mask_pending");
        expect_at(1, SEL_EO1, 32'h00, "held_mask_eff");
        tick();
        idle_in();
        rst     = 1'b1;
        rpt_ack = 1'b1;
        expect_at(0, SEL_RQ1, 32'h1, "held_req_before_rst");
        expect_at(1, SEL_RQ1, 32'h0, "rst_drops_req");
        tick();
        idle_in();
        rst     = 1'b0;
        rpt_ack = 1'b1;
        err_in  = 8'h12;
        expect_at(1, SEL_RQ0, 32'h1, "ack_idle_ignored");
        expect_at(1, SEL_RQ1, 32'h1, "held_rereq");
        tick();
        idle_in();
        expect_at(1, SEL_RQ0, 32'h1, "req_holds");
        expect_at(1, SEL_RQ1, 32'h1, "held_req_holds");

        repeat (3) tick();
        foreach (sbq[i]) begin
            checks++;
            errors++;
            $display("FAIL %s undrained cyc=%0d exp=%h",
                     sbq[i].name, sbq[i].cyc, sbq[i].exp);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
